// File: rtl/write_source_sched_pkg.sv
// Shared types and constants for the write-bus source scheduler.
package write_source_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_GRANT = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 65535;

  // Source IDs in painter's order: lowest ID is drawn first.
  localparam int unsigned SRC_BKG       = 0;
  localparam int unsigned SRC_STARFIELD = 1;
  localparam int unsigned SRC_GSENSCAL  = 2;

endpackage

// File: rtl/write_source_sched.sv
// Frame-synchronous scheduler handing the write bus to each requesting source
// in ascending ID order. Define WRITE_SCHED_TIMEOUT_EN to enable the grant watchdog.
module write_source_sched
  import write_source_sched_pkg::*;
#(
  parameter int unsigned MAX_WRITE_SOURCE = 2,
  parameter int unsigned SOURCE_SEL_ADDRW = $clog2(MAX_WRITE_SOURCE + 1),
  parameter int unsigned TIMEOUT_CYCLES   = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        frame,
  input  logic [MAX_WRITE_SOURCE:0]   src_req,
  input  logic [MAX_WRITE_SOURCE:0]   src_done,
  output logic [MAX_WRITE_SOURCE:0]   src_start,
  output logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
  output logic                        sched_busy,
  output logic                        swap_buffers,
  output logic                        frame_overrun
);

  localparam int unsigned NSRC = MAX_WRITE_SOURCE + 1;
  localparam logic [SOURCE_SEL_ADDRW-1:0] LAST_IDX = SOURCE_SEL_ADDRW'(MAX_WRITE_SOURCE);

  sched_state_e                state_q, state_d;
  logic [SOURCE_SEL_ADDRW-1:0] idx_q, idx_d;
  logic [NSRC-1:0]             start_q, start_d;
  logic                        swap_q, swap_d;
  logic                        ovr_q, ovr_d;
  logic                        busy_q, busy_d;
  logic                        wdog_expired;
  logic                        last_src;

  assign last_src = (idx_q == LAST_IDX);

`ifdef WRITE_SCHED_TIMEOUT_EN
  localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Fires on the TIMEOUT_CYCLES-th consecutive cycle spent in GRANT.
  assign wdog_expired = (state_q == ST_GRANT) &&
                        (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wdog_d = '0;
    if (state_q == ST_GRANT && state_d == ST_GRANT) begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign wdog_expired = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    start_d = '0;
    swap_d  = 1'b0;
    ovr_d   = 1'b0;

    if (frame) begin
      // A new frame always restarts the sequence; only a finished one may flip.
      idx_d   = '0;
      state_d = ST_SCAN;
      if (state_q == ST_SCAN || state_q == ST_GRANT) begin
        ovr_d = 1'b1;
      end
      if (state_q == ST_DONE) begin
        swap_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_SCAN: begin
          if (src_req[idx_q]) begin
            start_d = NSRC'(1) << idx_q;
            state_d = ST_GRANT;
          end else if (last_src) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + SOURCE_SEL_ADDRW'(1);
          end
        end
        ST_GRANT: begin
          if (src_done[idx_q] || wdog_expired) begin
            ovr_d = !src_done[idx_q];
            if (last_src) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + SOURCE_SEL_ADDRW'(1);
              state_d = ST_SCAN;
            end
          end
        end
        ST_DONE: ;
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      endcase
    end

    busy_d = (state_d == ST_SCAN) || (state_d == ST_GRANT);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      start_q <= '0;
      swap_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      start_q <= start_d;
      swap_q  <= swap_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign src_start        = start_q;
  assign write_source_sel = idx_q;
  assign sched_busy       = busy_q;
  assign swap_buffers     = swap_q;
  assign frame_overrun    = ovr_q;

endmodule

// File: tb/tb_write_source_sched.sv
// Directed bench for write_source_sched with a sequence-level reference model.
module tb_write_source_sched;

  localparam int unsigned MAXS = 2;
  localparam int unsigned TO   = 16;
`ifdef WRITE_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       frame = 1'b0;
  logic [2:0] src_req = '0;
  logic [2:0] src_done = '0;
  logic [2:0] src_start;
  logic [1:0] write_source_sel;
  logic       sched_busy;
  logic       swap_buffers;
  logic       frame_overrun;

  write_source_sched #(
    .MAX_WRITE_SOURCE(MAXS),
    .SOURCE_SEL_ADDRW(2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .frame(frame),
    .src_req(src_req),
    .src_done(src_done),
    .src_start(src_start),
    .write_source_sel(write_source_sel),
    .sched_busy(sched_busy),
    .swap_buffers(swap_buffers),
    .frame_overrun(frame_overrun)
  );

  always #20 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a drawing sequence walks sources 0..MAXS, waiting on each requester.
  bit          m_active = 0, m_waiting = 0, m_complete = 0;
  int unsigned m_cur = 0, m_gc = 0;
  logic [2:0]  e_start = '0;
  bit          e_swap = 0, e_ovr = 0;

  function automatic void move_on();
    m_waiting = 0;
    if (m_cur == MAXS) begin
      m_active   = 0;
      m_complete = 1;
    end else begin
      m_cur++;
    end
  endfunction

  initial forever begin
    @(posedge clk or negedge resetN);
    if (!resetN) begin
      m_active = 0; m_waiting = 0; m_complete = 0; m_cur = 0; m_gc = 0;
      e_start = '0; e_swap = 0; e_ovr = 0;
    end else begin
      e_start = '0; e_swap = 0; e_ovr = 0;
      if (frame) begin
        if (m_active) e_ovr = 1;
        else if (m_complete) e_swap = 1;
        m_active = 1; m_complete = 0; m_waiting = 0; m_cur = 0;
      end else if (m_active) begin
        if (!m_waiting) begin
          if (src_req[m_cur]) begin
            e_start[m_cur] = 1'b1;
            m_waiting = 1;
            m_gc = 0;
          end else begin
            move_on();
          end
        end else if (src_done[m_cur]) begin
          move_on();
        end else if (TO_EN) begin
          m_gc++;
          if (m_gc == TO) begin
            e_ovr = 1;
            move_on();
          end
        end
      end
    end
  end

  int start_log[$];
  int sel_log[$];

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("m_src_start", src_start, e_start);
      check("m_sel", write_source_sel, m_cur);
      check("m_busy", sched_busy, m_active);
      check("m_swap", swap_buffers, e_swap);
      check("m_overrun", frame_overrun, e_ovr);
      for (int i = 0; i < 3; i++) if (src_start[i] === 1'b1) start_log.push_back(i);
      if (sel_log.size() == 0 || sel_log[$] != int'(write_source_sel))
        sel_log.push_back(int'(write_source_sel));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame = 1'b1;
    tick(1);
    frame = 1'b0;
  endtask

  task automatic pulse_done(input int i);
    src_done = 3'b001 << i;
    tick(1);
    src_done = '0;
  endtask

  task automatic clear_logs();
    start_log.delete();
    sel_log.delete();
  endtask

  task automatic check_log(input string name, input int got[$], input int exp[$]);
    check({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check(name, got[i], exp[i]);
  endtask

  initial begin
    resetN = 1'b0;
    tick(2);
    cmp_en = 1'b1;
    check("rst_start", src_start, 3'b000);
    check("rst_sel", write_source_sel, 0);
    check("rst_busy", sched_busy, 0);
    check("rst_swap", swap_buffers, 0);
    check("rst_ovr", frame_overrun, 0);
    resetN = 1'b1;
    tick(2);

    // All three sources request; done pulses spaced ten cycles apart.
    src_req = 3'b111;
    frame_pulse();
    clear_logs();
    check("t1_busy", sched_busy, 1);
    check("t1_no_swap_from_idle", swap_buffers, 0);
    tick(1);
    check("t1_start0", src_start, 3'b001);
    tick(8);
    pulse_done(0);
    tick(1);
    check("t1_start1", src_start, 3'b010);
    tick(8);
    pulse_done(1);
    tick(1);
    check("t1_start2", src_start, 3'b100);
    tick(8);
    pulse_done(2);
    check("t1_done_busy", sched_busy, 0);
    check("t1_done_sel", write_source_sel, 2);
    check_log("t1_start_order", start_log, '{0, 1, 2});
    tick(3);

    // Source 1 idle: skipped in a single SCAN cycle.
    src_req = 3'b101;
    frame_pulse();
    check("t1_swap", swap_buffers, 1);
    clear_logs();
    tick(1);
    check("t1_swap_gone", swap_buffers, 0);
    check("t2_start0", src_start, 3'b001);
    src_req = 3'b010;
    tick(2);
    src_req = 3'b101;
    tick(1);
    pulse_done(0);
    check("t2_sel1", write_source_sel, 1);
    tick(1);
    check("t2_sel2", write_source_sel, 2);
    check("t2_no_start1", src_start, 3'b000);
    tick(1);
    check("t2_start2", src_start, 3'b100);
    tick(2);
    pulse_done(2);
    check_log("t2_start_order", start_log, '{0, 2});
    check_log("t2_sel_order", sel_log, '{0, 1, 2});

    // Frame while source 1 is granted.
    src_req = 3'b111;
    frame_pulse();
    check("t3_swap", swap_buffers, 1);
    tick(1);
    tick(2);
    pulse_done(0);
    tick(1);
    check("t3_start1", src_start, 3'b010);
    tick(3);
    frame_pulse();
    check("t3_ovr", frame_overrun, 1);
    check("t3_no_swap", swap_buffers, 0);
    check("t3_sel0", write_source_sel, 0);
    tick(1);
    check("t3_ovr_gone", frame_overrun, 0);
    check("t3_restart0", src_start, 3'b001);

    // Foreign done is ignored; frame beats a coincident done.
    src_done = 3'b010;
    tick(1);
    src_done = '0;
    check("t4_foreign_done_sel", write_source_sel, 0);
    pulse_done(0);
    tick(1);
    pulse_done(1);
    tick(1);
    check("t4_start2", src_start, 3'b100);
    tick(1);
    frame = 1'b1;
    src_done = 3'b100;
    tick(1);
    frame = 1'b0;
    src_done = '0;
    check("t4_ovr", frame_overrun, 1);
    check("t4_no_swap", swap_buffers, 0);
    check("t4_sel0", write_source_sel, 0);
    tick(1);
    check("t4_restart0", src_start, 3'b001);

    // Source 0 never finishes.
    if (TO_EN) begin
      tick(15);
      check("t5_pre_timeout_sel", write_source_sel, 0);
      check("t5_pre_timeout_ovr", frame_overrun, 0);
      tick(1);
      check("t5_timeout_sel", write_source_sel, 1);
      check("t5_timeout_ovr", frame_overrun, 1);
      tick(1);
      check("t5_start1", src_start, 3'b010);
    end else begin
      tick(40);
      check("t5_hold_sel", write_source_sel, 0);
      check("t5_hold_ovr", frame_overrun, 0);
      check("t5_hold_busy", sched_busy, 1);
    end

    // Asynchronous reset mid-grant.
    tick(2);
    #5;
    resetN = 1'b0;
    #1;
    check("t6_rst_start", src_start, 3'b000);
    check("t6_rst_sel", write_source_sel, 0);
    check("t6_rst_busy", sched_busy, 0);
    check("t6_rst_swap", swap_buffers, 0);
    check("t6_rst_ovr", frame_overrun, 0);
    tick(2);
    resetN = 1'b1;
    tick(1);
    check("t6_idle_busy", sched_busy, 0);

    // No requests: DONE after three SCAN cycles; first frame after reset never swaps.
    src_req = 3'b000;
    frame_pulse();
    check("t7_no_swap", swap_buffers, 0);
    check("t7_busy", sched_busy, 1);
    tick(2);
    check("t7_sel2", write_source_sel, 2);
    check("t7_busy_still", sched_busy, 1);
    tick(1);
    check("t7_done", sched_busy, 0);
    frame_pulse();
    check("t7_swap", swap_buffers, 1);
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
